game_sequencer: RTL and testbench

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/game_sequencer.sv | 173 +++++++++++++++++
 tb/tb_game_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// game_sequencer: top-level game flow for a two-player paddle game.
// Walks MENU -> SET -> START -> PLAY -> END_POINT -> (START | END_GAME) -> MENU.
// It keeps the scores, the winning score, the serve side and the end-of-point hold timer.
// Every output is a flop, so a state change shows one clk_pix after the edge, hit or tick that caused it.
module game_sequencer #(
   parameter int MAX_SCORE_DEFAULT = 5,
   parameter int HOLD_FRAMES       = 60
) (
   input  logic       clk_pix,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       btn_launch,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       left_hit,
   input  logic       right_hit,
   output logic [2:0] state,
   output logic [4:0] score_p1,
   output logic [4:0] score_p2,
   output logic [4:0] max_score,
   output logic       serve_side,
   output logic       ball_park,
   output logic       ball_run,
   output logic       winner
);

   typedef enum logic [2:0] {
      ST_MENU      = 3'd0,
      ST_SET       = 3'd1,
      ST_START     = 3'd2,
      ST_PLAY      = 3'd3,
      ST_END_POINT = 3'd4,
      ST_END_GAME  = 3'd5
   } state_t;

   localparam int              HOLD_W        = (HOLD_FRAMES < 1) ? 1 : $clog2(HOLD_FRAMES + 1);
   localparam logic [HOLD_W-1:0] HOLD_LOAD   = HOLD_W'(HOLD_FRAMES);
   localparam logic [4:0]      MAX_SCORE_RST = 5'(MAX_SCORE_DEFAULT);
   localparam logic [4:0]      SCORE_CEIL    = 5'd31;
   localparam logic [4:0]      SCORE_FLOOR   = 5'd1;

   // The state register is a plain vector, so the unused codes 6 and 7 can be caught and recovered.
   logic [2:0]        state_q, state_d;
   logic [4:0]        score_p1_q, score_p1_d;
   logic [4:0]        score_p2_q, score_p2_d;
   logic [4:0]        max_score_q, max_score_d;
   logic              serve_side_q, serve_side_d;
   logic              winner_q, winner_d;
   logic              ball_park_q, ball_park_d;
   logic              ball_run_q, ball_run_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              launch_prev_q, launch_prev_d;
   logic              up_prev_q, up_prev_d;
   logic              down_prev_q, down_prev_d;

   logic launch_edge, up_edge, down_edge;

   // A button acts only on the cycle it goes from low to high; holding it does nothing more.
   always_comb begin
      launch_prev_d = btn_launch;
      up_prev_d     = btn_up;
      down_prev_d   = btn_down;
      launch_edge   = btn_launch & ~launch_prev_q;
      up_edge       = btn_up & ~up_prev_q;
      down_edge     = btn_down & ~down_prev_q;
   end

   // Compute the next state and the next values of all registered outputs.
   always_comb begin
      state_d      = state_q;
      score_p1_d   = score_p1_q;
      score_p2_d   = score_p2_q;
      max_score_d  = max_score_q;
      serve_side_d = serve_side_q;
      winner_d     = winner_q;
      hold_d       = hold_q;

      case (state_q)
         ST_MENU: begin
            if (launch_edge) begin
               state_d    = ST_SET;
               score_p1_d = '0;
               score_p2_d = '0;
               winner_d   = 1'b0;
            end
         end
         ST_SET: begin
            // Launch wins over a simultaneous up or down edge, which is then dropped.
            if (launch_edge) begin
               state_d = ST_START;
            end else if (up_edge && !down_edge) begin
               if (max_score_q < SCORE_CEIL) max_score_d = max_score_q + 5'd1;
            end else if (down_edge && !up_edge) begin
               if (max_score_q > SCORE_FLOOR) max_score_d = max_score_q - 5'd1;
            end
         end
         ST_START: begin
            if (launch_edge) state_d = ST_PLAY;
         end
         ST_PLAY: begin
            // If both goal lines fire in the same cycle, left_hit wins: only one point is awarded.
            if (left_hit) begin
               if (score_p2_q < max_score_q) score_p2_d = score_p2_q + 5'd1;
               serve_side_d = 1'b0;
               hold_d       = HOLD_LOAD;
               state_d      = ST_END_POINT;
            end else if (right_hit) begin
               if (score_p1_q < max_score_q) score_p1_d = score_p1_q + 5'd1;
               serve_side_d = 1'b1;
               hold_d       = HOLD_LOAD;
               state_d      = ST_END_POINT;
            end
         end
         ST_END_POINT: begin
            if (frame_tick) begin
               if (hold_q != '0) begin
                  hold_d = hold_q - 1'b1;
               end else if ((score_p1_q == max_score_q) || (score_p2_q == max_score_q)) begin
                  state_d  = ST_END_GAME;
                  winner_d = (score_p1_q == max_score_q) ? 1'b0 : 1'b1;
               end else begin
                  state_d = ST_START;
               end
            end
         end
         ST_END_GAME: begin
            if (launch_edge) state_d = ST_MENU;
         end
         default: state_d = ST_MENU;
      endcase

      ball_park_d = (state_d == ST_START);
      ball_run_d  = (state_d == ST_PLAY);
   end

   // Register the state and outputs. Reset overrides everything, but the button history keeps tracking the inputs.
   always_ff @(posedge clk_pix) begin
      launch_prev_q <= launch_prev_d;
      up_prev_q     <= up_prev_d;
      down_prev_q   <= down_prev_d;
      if (reset) begin
         state_q      <= ST_MENU;
         score_p1_q   <= '0;
         score_p2_q   <= '0;
         max_score_q  <= MAX_SCORE_RST;
         serve_side_q <= 1'b0;
         winner_q     <= 1'b0;
         ball_park_q  <= 1'b0;
         ball_run_q   <= 1'b0;
         hold_q       <= '0;
      end else begin
         state_q      <= state_d;
         score_p1_q   <= score_p1_d;
         score_p2_q   <= score_p2_d;
         max_score_q  <= max_score_d;
         serve_side_q <= serve_side_d;
         winner_q     <= winner_d;
         ball_park_q  <= ball_park_d;
         ball_run_q   <= ball_run_d;
         hold_q       <= hold_d;
      end
   end

   assign state      = state_q;
   assign score_p1   = score_p1_q;
   assign score_p2   = score_p2_q;
   assign max_score  = max_score_q;
   assign serve_side = serve_side_q;
   assign winner     = winner_q;
   assign ball_park  = ball_park_q;
   assign ball_run   = ball_run_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed testbench for game_sequencer.
// Inputs change on the falling edge, and outputs are sampled on the falling edge before any new drive.
module tb_game_sequencer;

   logic       clk_pix = 1'b0;
   logic       reset = 1'b0;
   logic       frame_tick = 1'b0;
   logic       btn_launch = 1'b0;
   logic       btn_up = 1'b0;
   logic       btn_down = 1'b0;
   logic       left_hit = 1'b0;
   logic       right_hit = 1'b0;
   logic [2:0] state;
   logic [4:0] score_p1, score_p2, max_score;
   logic       serve_side, ball_park, ball_run, winner;

   int checks = 0;
   int failures = 0;

   localparam logic [2:0] S_MENU = 3'd0, S_SET = 3'd1, S_START = 3'd2,
                          S_PLAY = 3'd3, S_END_POINT = 3'd4, S_END_GAME = 3'd5;

   game_sequencer #(.MAX_SCORE_DEFAULT(5), .HOLD_FRAMES(60)) dut (
      .clk_pix(clk_pix), .reset(reset), .frame_tick(frame_tick),
      .btn_launch(btn_launch), .btn_up(btn_up), .btn_down(btn_down),
      .left_hit(left_hit), .right_hit(right_hit),
      .state(state), .score_p1(score_p1), .score_p2(score_p2),
      .max_score(max_score), .serve_side(serve_side),
      .ball_park(ball_park), .ball_run(ball_run), .winner(winner)
   );

   // clock / reset
   always #5 clk_pix = ~clk_pix;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clk_pix); reset = 1'b1;
      repeat (cycles) @(negedge clk_pix);
      reset = 1'b0;
   endtask

   // driver tasks: each pulse is one cycle high, then one cycle low
   task automatic press_launch();
      @(negedge clk_pix); btn_launch = 1'b1;
      @(negedge clk_pix); btn_launch = 1'b0;
   endtask

   task automatic press_up(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk_pix); btn_up = 1'b1;
         @(negedge clk_pix); btn_up = 1'b0;
      end
   endtask

   task automatic press_down(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk_pix); btn_down = 1'b1;
         @(negedge clk_pix); btn_down = 1'b0;
      end
   endtask

   task automatic pulse_hits(input logic l, input logic r);
      @(negedge clk_pix); left_hit = l; right_hit = r;
      @(negedge clk_pix); left_hit = 1'b0; right_hit = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk_pix); frame_tick = 1'b1;
         @(negedge clk_pix); frame_tick = 1'b0;
      end
   endtask

   initial begin
      // reset values, sampled while reset is still high
      @(negedge clk_pix); reset = 1'b1;
      repeat (3) @(negedge clk_pix);
      check_val("rst_state", state, S_MENU);
      check_val("rst_p1", score_p1, 0);
      check_val("rst_p2", score_p2, 0);
      check_val("rst_max", max_score, 5);
      check_val("rst_serve", serve_side, 0);
      check_val("rst_winner", winner, 0);
      check_val("rst_park", ball_park, 0);
      check_val("rst_run", ball_run, 0);
      reset = 1'b0;

      // menu ignores up and hits
      press_up(1);
      pulse_hits(1'b1, 1'b0);
      check_val("menu_ignore_state", state, S_MENU);
      check_val("menu_ignore_max", max_score, 5);

      // launch, up x3, down x1, launch
      press_launch();
      check_val("set_state", state, S_SET);
      press_up(3);
      press_down(1);
      check_val("set_max7", max_score, 7);
      press_launch();
      check_val("start_state", state, S_START);
      check_val("start_park", ball_park, 1);
      check_val("start_max7", max_score, 7);

      // hits ignored in START; launch goes to PLAY
      pulse_hits(1'b0, 1'b1);
      check_val("start_hit_ignored", score_p1, 0);
      press_launch();
      check_val("play_state", state, S_PLAY);
      check_val("play_run", ball_run, 1);
      check_val("play_park", ball_park, 0);

      // a right hit scores for p1, p1 serves, then the 60-frame hold
      pulse_hits(1'b0, 1'b1);
      check_val("rh_state", state, S_END_POINT);
      check_val("rh_p1", score_p1, 1);
      check_val("rh_serve", serve_side, 1);
      check_val("rh_run", ball_run, 0);
      pulse_hits(1'b1, 1'b0);
      check_val("ep_hit_ignored", score_p2, 0);
      ticks(60);
      check_val("ep_after60", state, S_END_POINT);
      ticks(1);
      check_val("ep_after61", state, S_START);

      // saturation of the winning score at both ends, and launch priority
      do_reset(2);
      press_launch();
      press_down(10);
      check_val("sat_low", max_score, 1);
      @(negedge clk_pix); btn_up = 1'b1; btn_down = 1'b1;
      @(negedge clk_pix); btn_up = 1'b0; btn_down = 1'b0;
      check_val("up_down_same", max_score, 1);
      press_up(40);
      check_val("sat_high", max_score, 31);
      @(negedge clk_pix); btn_launch = 1'b1; btn_down = 1'b1;
      @(negedge clk_pix); btn_launch = 1'b0; btn_down = 1'b0;
      check_val("launch_prio_state", state, S_START);
      check_val("launch_prio_max", max_score, 31);

      // simultaneous hits award exactly one point, to p2
      do_reset(2);
      press_launch(); press_launch(); press_launch();
      pulse_hits(1'b1, 1'b1);
      check_val("both_p2", score_p2, 1);
      check_val("both_p1", score_p1, 0);
      check_val("both_serve", serve_side, 0);

      // a reset in the middle of END_POINT returns everything to its reset values
      do_reset(1);
      check_val("midrst_state", state, S_MENU);
      check_val("midrst_p2", score_p2, 0);

      // a full game to 2 points, won by p2
      press_launch();
      press_down(3);
      check_val("g_max2", max_score, 2);
      press_launch(); press_launch();
      pulse_hits(1'b1, 1'b0);
      check_val("g_p2_1", score_p2, 1);
      ticks(61);
      check_val("g_back_start", state, S_START);
      press_launch();
      pulse_hits(1'b1, 1'b0);
      check_val("g_p2_2", score_p2, 2);
      ticks(61);
      check_val("g_end_state", state, S_END_GAME);
      check_val("g_winner", winner, 1);
      press_launch();
      check_val("g_menu", state, S_MENU);
      check_val("g_hold_p1", score_p1, 0);
      check_val("g_hold_p2", score_p2, 2);
      press_launch();
      check_val("g_reenter_p2", score_p2, 0);

      // launch held through reset and afterwards produces no edge
      @(negedge clk_pix); btn_launch = 1'b1; reset = 1'b1;
      repeat (3) @(negedge clk_pix);
      reset = 1'b0;
      repeat (5) @(negedge clk_pix);
      check_val("held_launch", state, S_MENU);
      btn_launch = 1'b0;
      press_launch();
      check_val("after_release", state, S_SET);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
